// File: rtl/vector_pkg.sv
// Shared definitions for the vector display list: entry field positions,
// entry kinds and the decode helper used by the list reader.
package vector_pkg;

    localparam int ENTRY_W  = 18;
    localparam int X_MSB    = 17;
    localparam int X_LSB    = 10;
    localparam int Y_MSB    = 9;
    localparam int Y_LSB    = 2;
    localparam int LINE_BIT = 1;
    localparam int POS_BIT  = 0;

    typedef enum logic [1:0] {
        ENT_DOT  = 2'b00,
        ENT_MOVE = 2'b01,
        ENT_LINE = 2'b10,
        ENT_END  = 2'b11
    } entry_kind_e;

    localparam logic [ENTRY_W-1:0] END_MARKER = {16'd0, 2'b11};

    function automatic entry_kind_e decode_entry(input logic [ENTRY_W-1:0] word);
        return entry_kind_e'({word[LINE_BIT], word[POS_BIT]});
    endfunction

endpackage

// File: rtl/vector_list_reader.sv
// Walks the completed display list in RAM and converts move/line/dot entries
// into absolute segments for the line drawer; pulses halt at the end marker.
module vector_list_reader
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH   = 8,
    parameter int ADR_WIDTH   = 16,
    parameter int DATAWIDTH   = 18,
    parameter int MAX_ENTRIES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic                 halt,
    output logic [ADR_WIDTH-1:0] adrREAD,
    input  logic [DATAWIDTH-1:0] dataREAD,
    output logic                 seg_valid,
    input  logic                 seg_ready,
    output logic [OUT_WIDTH-1:0] x0,
    output logic [OUT_WIDTH-1:0] y0,
    output logic [OUT_WIDTH-1:0] x1,
    output logic [OUT_WIDTH-1:0] y1,
    output logic [ADR_WIDTH-1:0] seg_count,
    output logic [2:0]           state_debug
);

    typedef enum logic [2:0] {
        S_WAIT_GO     = 3'd0,
        S_ADDR        = 3'd1,
        S_DECODE      = 3'd2,
        S_EMIT        = 3'd3,
        S_END_PASS    = 3'd4,
        S_WAIT_GO_LOW = 3'd5
    } rd_state_e;

    localparam logic [ADR_WIDTH-1:0] LAST_ADR = ADR_WIDTH'(MAX_ENTRIES - 1);

    rd_state_e              r_state;
    rd_state_e              w_state_nxt;
    logic                   r_halt;
    logic                   w_halt_nxt;
    logic [ADR_WIDTH-1:0]   r_adr;
    logic [ADR_WIDTH-1:0]   w_adr_nxt;
    logic [ADR_WIDTH-1:0]   r_seg_count;
    logic [ADR_WIDTH-1:0]   w_seg_count_nxt;
    logic                   r_seg_valid;
    logic                   w_seg_valid_nxt;
    logic [OUT_WIDTH-1:0]   r_x0, r_y0, r_x1, r_y1;
    logic [OUT_WIDTH-1:0]   w_x0_nxt, w_y0_nxt, w_x1_nxt, w_y1_nxt;
    logic [OUT_WIDTH-1:0]   r_cx, r_cy;
    logic [OUT_WIDTH-1:0]   w_cx_nxt, w_cy_nxt;
    logic                   r_go_lost;
    logic                   w_go_lost_nxt;

    entry_kind_e            w_kind;
    logic [OUT_WIDTH-1:0]   w_ex;
    logic [OUT_WIDTH-1:0]   w_ey;
    logic                   w_pass_done;
    logic                   w_handshake;

    assign w_kind      = decode_entry(dataREAD[ENTRY_W-1:0]);
    assign w_ex        = OUT_WIDTH'(dataREAD[X_MSB:X_LSB]);
    assign w_ey        = OUT_WIDTH'(dataREAD[Y_MSB:Y_LSB]);
    // The address guard ends a pass even if the last word is a drawable entry.
    assign w_pass_done = (w_kind == ENT_END) || (r_adr == LAST_ADR);
    assign w_handshake = r_seg_valid & seg_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_WAIT_GO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_GO: begin
                if (go) begin
                    w_state_nxt = S_ADDR;
                end else begin
                    w_state_nxt = S_WAIT_GO;
                end
            end
            S_ADDR: begin
                if (!go) begin
                    w_state_nxt = S_WAIT_GO_LOW;
                end else begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!go) begin
                    w_state_nxt = S_WAIT_GO_LOW;
                end else if (w_pass_done) begin
                    w_state_nxt = S_END_PASS;
                end else if (w_kind == ENT_MOVE) begin
                    w_state_nxt = S_ADDR;
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                // A go drop seen at any point while emitting aborts only after the handshake.
                if (w_handshake) begin
                    if (r_go_lost || !go) begin
                        w_state_nxt = S_WAIT_GO_LOW;
                    end else begin
                        w_state_nxt = S_ADDR;
                    end
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_END_PASS: begin
                w_state_nxt = S_WAIT_GO_LOW;
            end
            S_WAIT_GO_LOW: begin
                if (!go) begin
                    w_state_nxt = S_WAIT_GO;
                end else begin
                    w_state_nxt = S_WAIT_GO_LOW;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_GO;
            end
        endcase
    end

    // Next values of the registered outputs and the current point.
    always_comb begin
        w_halt_nxt      = 1'b0;
        w_adr_nxt       = r_adr;
        w_seg_count_nxt = r_seg_count;
        w_seg_valid_nxt = r_seg_valid;
        w_x0_nxt        = r_x0;
        w_y0_nxt        = r_y0;
        w_x1_nxt        = r_x1;
        w_y1_nxt        = r_y1;
        w_cx_nxt        = r_cx;
        w_cy_nxt        = r_cy;
        w_go_lost_nxt   = r_go_lost;
        case (r_state)
            S_WAIT_GO: begin
                if (go) begin
                    w_adr_nxt       = {ADR_WIDTH{1'b0}};
                    w_seg_count_nxt = {ADR_WIDTH{1'b0}};
                    w_cx_nxt        = {OUT_WIDTH{1'b0}};
                    w_cy_nxt        = {OUT_WIDTH{1'b0}};
                    w_go_lost_nxt   = 1'b0;
                end else begin
                    w_go_lost_nxt   = 1'b0;
                end
            end
            S_DECODE: begin
                if (!go) begin
                    w_halt_nxt = 1'b0;
                end else if (w_pass_done) begin
                    w_halt_nxt = 1'b1;
                end else begin
                    case (w_kind)
                        ENT_MOVE: begin
                            w_cx_nxt  = w_ex;
                            w_cy_nxt  = w_ey;
                            w_adr_nxt = r_adr + {{(ADR_WIDTH-1){1'b0}}, 1'b1};
                        end
                        ENT_LINE: begin
                            w_x0_nxt        = r_cx;
                            w_y0_nxt        = r_cy;
                            w_x1_nxt        = w_ex;
                            w_y1_nxt        = w_ey;
                            w_seg_valid_nxt = 1'b1;
                        end
                        ENT_DOT: begin
                            w_x0_nxt        = w_ex;
                            w_y0_nxt        = w_ey;
                            w_x1_nxt        = w_ex;
                            w_y1_nxt        = w_ey;
                            w_seg_valid_nxt = 1'b1;
                        end
                        default: begin
                            w_halt_nxt = 1'b0;
                        end
                    endcase
                end
            end
            S_EMIT: begin
                if (w_handshake) begin
                    w_seg_valid_nxt = 1'b0;
                    w_seg_count_nxt = r_seg_count + {{(ADR_WIDTH-1){1'b0}}, 1'b1};
                    w_cx_nxt        = r_x1;
                    w_cy_nxt        = r_y1;
                    w_adr_nxt       = r_adr + {{(ADR_WIDTH-1){1'b0}}, 1'b1};
                    w_go_lost_nxt   = 1'b0;
                end else begin
                    w_go_lost_nxt   = r_go_lost | ~go;
                end
            end
            S_END_PASS: begin
                w_adr_nxt = {ADR_WIDTH{1'b0}};
            end
            default: begin
                w_halt_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halt      <= 1'b0;
            r_adr       <= {ADR_WIDTH{1'b0}};
            r_seg_count <= {ADR_WIDTH{1'b0}};
            r_seg_valid <= 1'b0;
            r_x0        <= {OUT_WIDTH{1'b0}};
            r_y0        <= {OUT_WIDTH{1'b0}};
            r_x1        <= {OUT_WIDTH{1'b0}};
            r_y1        <= {OUT_WIDTH{1'b0}};
            r_cx        <= {OUT_WIDTH{1'b0}};
            r_cy        <= {OUT_WIDTH{1'b0}};
            r_go_lost   <= 1'b0;
        end else begin
            r_halt      <= w_halt_nxt;
            r_adr       <= w_adr_nxt;
            r_seg_count <= w_seg_count_nxt;
            r_seg_valid <= w_seg_valid_nxt;
            r_x0        <= w_x0_nxt;
            r_y0        <= w_y0_nxt;
            r_x1        <= w_x1_nxt;
            r_y1        <= w_y1_nxt;
            r_cx        <= w_cx_nxt;
            r_cy        <= w_cy_nxt;
            r_go_lost   <= w_go_lost_nxt;
        end
    end

    assign halt        = r_halt;
    assign adrREAD     = r_adr;
    assign seg_count   = r_seg_count;
    assign seg_valid   = r_seg_valid;
    assign x0          = r_x0;
    assign y0          = r_y0;
    assign x1          = r_x1;
    assign y1          = r_y1;
    assign state_debug = r_state;

endmodule

// File: tb/tb_vector_list_reader.sv
// Directed and randomized bench for vector_list_reader with a list-level
// reference model of the expected segments.
module tb_vector_list_reader;
    import vector_pkg::*;

    localparam int OW   = 8;
    localparam int AW   = 16;
    localparam int DW   = 18;
    localparam int MAXE = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          halt;
    logic [AW-1:0] adrREAD;
    logic [DW-1:0] dataREAD;
    logic          seg_valid;
    logic          seg_ready;
    logic [OW-1:0] x0, y0, x1, y1;
    logic [AW-1:0] seg_count;
    logic [2:0]    state_debug;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:15];
    logic [31:0]   exp_q [$];
    int            exp_cnt;

    vector_list_reader #(
        .OUT_WIDTH(OW), .ADR_WIDTH(AW), .DATAWIDTH(DW), .MAX_ENTRIES(MAXE)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .halt(halt), .adrREAD(adrREAD),
        .dataREAD(dataREAD), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .seg_count(seg_count),
        .state_debug(state_debug)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data follows the address by one cycle.
    always @(posedge clk) dataREAD <= mem[adrREAD[3:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] k, input logic [7:0] x, input logic [7:0] y);
        return {x, y, k};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = END_MARKER;
    endtask

    // Reference: walk the list as the builder defined it.
    task automatic build_expect();
        logic [7:0] cx = 8'd0;
        logic [7:0] cy = 8'd0;
        logic [7:0] ex, ey;
        exp_q.delete();
        for (int i = 0; i < MAXE; i++) begin
            if (mem[i][1:0] == 2'b11 || i == MAXE - 1) break;
            ex = mem[i][17:10];
            ey = mem[i][9:2];
            if (mem[i][1:0] == 2'b10) exp_q.push_back({cx, cy, ex, ey});
            if (mem[i][1:0] == 2'b00) exp_q.push_back({ex, ey, ex, ey});
            cx = ex;
            cy = ey;
        end
        exp_cnt = exp_q.size();
    endtask

    task automatic rand_list(input bit with_end);
        int len;
        logic [1:0] k;
        len = with_end ? int'($urandom_range(1, 7)) : MAXE;
        clear_mem();
        mem[0] = mk(ENT_MOVE, 8'd0, 8'd0);
        for (int i = 1; i < len; i++) begin
            k = 2'($urandom_range(2));
            mem[i] = mk(k, 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic go_low();
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Run one pass from WAIT_GO, checking segments, stability under stall and wrap-up.
    task automatic run_pass(input string tag, input int ready_pct, input int stall_first);
        int          cyc = 0;
        int          halts = 0;
        int          after = 0;
        int          stall = stall_first;
        logic        pend = 1'b0;
        logic [31:0] held = 32'd0;
        logic [AW-1:0] held_adr = '0;
        logic [32:0] expv;
        build_expect();
        @(negedge clk);
        go = 1'b1;
        seg_ready = 1'b0;
        while (cyc < 300 && after < 3) begin
            @(negedge clk);
            cyc++;
            if (halt) halts++;
            if (halts > 0) after++;
            if (pend) chk({tag, " hold"}, {seg_valid, x0, y0, x1, y1, adrREAD}, {1'b1, held, held_adr});
            if (seg_valid) begin
                if (stall > 0) begin
                    seg_ready = 1'b0;
                    stall--;
                end else begin
                    seg_ready = ($urandom_range(99) < ready_pct);
                end
            end else begin
                seg_ready = 1'($urandom_range(1));
            end
            pend = seg_valid && !seg_ready;
            held = {x0, y0, x1, y1};
            held_adr = adrREAD;
            if (seg_valid && seg_ready) begin
                expv = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : {1'b1, 32'd0};
                chk({tag, " seg"}, {1'b0, x0, y0, x1, y1}, expv);
            end
        end
        seg_ready = 1'b0;
        chk({tag, " finished in budget"}, (after >= 3), 1);
        chk({tag, " halt pulses"}, halts, 1);
        chk({tag, " seg_count"}, seg_count, exp_cnt);
        chk({tag, " adr back to 0"}, adrREAD, 0);
        chk({tag, " missing segs"}, exp_q.size(), 0);
        chk({tag, " state wait_go_low"}, state_debug, 5);
    endtask

    initial begin
        int  n;
        bit  seen;
        rst = 1'b0;
        go = 1'b0;
        seg_ready = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("reset state", state_debug, 0);
        chk("reset outs", {halt, seg_valid, adrREAD, seg_count, x0, y0, x1, y1}, 0);
        rst = 1'b1;

        // Square list, drawer always ready.
        clear_mem();
        mem[0] = mk(ENT_MOVE, 8'd10, 8'd10);
        mem[1] = mk(ENT_LINE, 8'd50, 8'd10);
        mem[2] = mk(ENT_LINE, 8'd50, 8'd50);
        go_low();
        run_pass("square", 100, 0);

        // Handoff: go held high after halt must not start a second pass.
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (halt || seg_valid) seen = 1'b1;
        end
        chk("handoff idle", {seen, state_debug}, {1'b0, 3'd5});
        go_low();
        run_pass("second pass", 100, 0);

        // Backpressure on the first segment.
        go_low();
        run_pass("backpressure", 100, 5);

        // Single dot.
        clear_mem();
        mem[0] = mk(ENT_DOT, 8'd200, 8'd7);
        go_low();
        run_pass("dot", 100, 0);

        // Empty list: halt three clocks after go, no segment.
        clear_mem();
        go_low();
        @(negedge clk);
        go = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!halt && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (seg_valid) seen = 1'b1;
        end
        chk("empty halt latency", n, 3);
        chk("empty no seg", {seen, seg_count}, 0);

        // go dropped in ADDR: abort without halt.
        clear_mem();
        mem[0] = mk(ENT_MOVE, 8'd1, 8'd2);
        mem[1] = mk(ENT_LINE, 8'd3, 8'd4);
        go_low();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        chk("abort to wait_go_low", {halt, state_debug}, {1'b0, 3'd5});
        @(negedge clk);
        chk("abort back to wait_go", {halt, state_debug}, {1'b0, 3'd0});

        // Address guard: no end marker within MAXE entries.
        rand_list(1'b0);
        go_low();
        run_pass("guard", 70, 0);

        // Random lists with random drawer readiness.
        for (int t = 0; t < 6; t++) begin
            rand_list(1'b1);
            go_low();
            run_pass("random", 60, 0);
        end

        // Reset while a segment is pending.
        clear_mem();
        mem[0] = mk(ENT_MOVE, 8'd10, 8'd10);
        mem[1] = mk(ENT_LINE, 8'd50, 8'd10);
        go_low();
        @(negedge clk);
        go = 1'b1;
        seg_ready = 1'b0;
        n = 0;
        while (!seg_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("emit reached", seg_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid-emit reset state", state_debug, 0);
        chk("mid-emit reset outs", {halt, seg_valid, adrREAD, seg_count, x0, y0, x1, y1}, 0);
        @(negedge clk);
        go = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
